decode_ctrl_stage: RTL and testbench
====================================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter MUL_CYCLES, default 3: cycles a multiply occupies the execute stage, legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 8: cycles a divide or remainder occupies the execute stage, legal range 1..15.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 validD  in  1  decode slot holds a real instruction.
REQ-007 opcode  in  7  instruction[6:0].
REQ-008 funct3  in  3  instruction[14:12].
REQ-009 funct7  in  7  instruction[31:25].
REQ-010 StallD  in  1  hazard unit holds decode; ID/EX register keeps its value.
REQ-011 FlushE  in  1  hazard unit squashes execute; ID/EX register loads a bubble.
REQ-012 ImmSrcD  out  3  combinational immediate select: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-013 Registered ID/EX outputs, all 1 bit unless stated: RegWriteE, ResultSrcE[2] (00 ALU, 01 memory, 10 PC+4), ALUsrcE, MemWriteE, BranchE, JumpE, jalrE, luiE, R_sizeE[3], DMem_sizeE[3], ALUControlE[4], MulDivE, MDOpE[3], IllegalE.
REQ-014 md_stall  out  1  multi-cycle operation in progress; front end must hold.
REQ-015 md_done  out  1  one-cycle pulse when a multi-cycle result is ready.

Function
REQ-016 Decoding covers RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
REQ-017 R_size and DMem_size equal funct3 for LOAD and STORE instructions, and 010 for all other instructions.
REQ-018 ALUControl encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
- SUB is selected only for OP with funct7[5]=1.
- SRA is selected for OP or OP-IMM with funct3=101 and funct7[5]=1.
- BRANCH selects SUB.
- LUI selects PASSB.
REQ-019 An unknown opcode, or validD=0, loads a bubble.
- A bubble has all control fields 0.
- IllegalE=1 only when validD=1 and the opcode is unknown.
REQ-020 ID/EX update priority: rst, then FlushE (bubble), then StallD or md_stall (hold), then load the decode.
REQ-021 FSM states and transitions:
- IDLE to BUSY when a multi-cycle operation is loaded into ID/EX.
- BUSY to DONE when the down-counter reaches 0.
- DONE to IDLE unconditionally after one cycle.
REQ-022 On entry to BUSY, the 4-bit counter loads MUL_CYCLES-1 when funct3[2]=0, and DIV_CYCLES-1 when funct3[2]=1.
REQ-023 The counter decrements once per cycle in BUSY.
REQ-024 md_stall=1 in BUSY.
REQ-025 md_done=1 in DONE, and md_stall=0 in DONE.
REQ-026 With a cycle count of 1, the FSM goes IDLE to BUSY to DONE, giving a minimum of 1 stall cycle.
REQ-027 ID/EX holds the multi-cycle instruction throughout BUSY and DONE.
REQ-028 The ID/EX register accepts a new decode in DONE when StallD=0.
REQ-029 FlushE in BUSY or DONE aborts the operation: next state IDLE, md_done not pulsed, ID/EX loads a bubble.
REQ-030 FlushE and a multi-cycle decode in the same cycle: the flush wins and the FSM stays in IDLE.
REQ-031 StallD=1 in IDLE blocks entry to BUSY.

Reset
REQ-032 Reset values: all ID/EX outputs 0, FSM state IDLE, counter 0, md_stall 0, md_done 0.
REQ-033 Reset asserted mid-operation aborts the operation at the next clock edge with no md_done pulse.

Configuration
REQ-034 Macro M_EXT_EN selects RV32M support.
REQ-035 With M_EXT_EN defined, OP with funct7=0000001 decodes as multi-cycle with these fields:
- MulDivE=1, MDOpE=funct3, RegWriteE=1, ResultSrcE=00.
REQ-036 Without M_EXT_EN:
- OP with funct7=0000001 decodes as illegal (REQ-019).
- The FSM and counter are not built.
- md_stall, md_done, MulDivE and MDOpE are tied to 0.

Structure
REQ-037 Package ctrl_pkg holds these shared definitions:
- the ALUControl, ResultSrc and ImmSrc encodings;
- the opcode constants;
- the FSM state enum (IDLE, BUSY, DONE).
REQ-038 A single combinational sub-module, ctrl_decode, produces the next ID/EX control bundle and ImmSrcD.
REQ-039 decode_ctrl_stage holds the ID/EX register, the FSM and the counter.

Verification
REQ-040 Reset then an ADD instruction (opcode 0110011, funct3 000, funct7 0000000) with validD=1 -> the next cycle shows RegWriteE=1, ALUControlE=0, ALUsrcE=0, ResultSrcE=00, IllegalE=0.
REQ-041 Decoding an LB instruction (opcode 0000011, funct3 000) -> ResultSrcE=01, ALUsrcE=1, R_sizeE=000, ImmSrcD=000.
REQ-042 With M_EXT_EN defined and DIV_CYCLES=8, decode a DIV instruction (funct7 0000001, funct3 100) -> md_stall=1 for exactly 8 cycles, then md_done=1 for 1 cycle, with ID/EX unchanged throughout.
REQ-043 Decode a MUL instruction, then assert FlushE in the 2nd BUSY cycle -> the next cycle shows state IDLE, all control fields 0, and md_done is never pulsed.
REQ-044 Apply opcode 1111111 with validD=1 -> IllegalE=1, RegWriteE=0, MemWriteE=0; apply the same with validD=0 -> IllegalE=0.
REQ-045 Assert rst in the 3rd BUSY cycle of a DIV -> the next cycle shows all outputs 0 and state IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: encodings and types shared by the decode-stage control logic.
//   - ALUControl, ResultSrc and ImmSrc encodings
//   - RV32I opcode constants and the RV32M funct7 marker
//   - ID/EX control bundle (ctrl_t) and the multi-cycle FSM state enum
//   - alu_from_funct3: ALU operation for OP / OP-IMM arithmetic
package ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       lui;
        logic [2:0] r_size;
        logic [2:0] dmem_size;
        logic [3:0] alu_control;
        logic       mul_div;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    // alt is funct7[5]; SUB is only reachable from register-register OP.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic       alt,
                                                   input logic       allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I (optionally RV32M) control decoder.
// Macro M_EXT_EN: when defined, OP with funct7=0000001 decodes as a
// multi-cycle multiply/divide; otherwise it is reported as illegal.
// Ports:
//   validD  - decode slot holds a real instruction
//   opcode, funct3, funct7 - instruction fields
//   ctrl    - next ID/EX control bundle (all zero for a bubble)
//   ImmSrcD - immediate format select, derived from opcode alone
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic       validD,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic [2:0] ImmSrcD
);

    ctrl_t dec;
    logic  known;

    always_comb begin
        dec           = '0;
        dec.r_size    = SIZE_WORD;
        dec.dmem_size = SIZE_WORD;
        known         = 1'b1;
        ImmSrcD       = IMM_I;

        case (opcode)
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.lui         = 1'b1;
                dec.alu_control = ALU_PASSB;
                ImmSrcD         = IMM_U;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                ImmSrcD       = IMM_U;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                ImmSrcD        = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                ImmSrcD         = IMM_B;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_MEM;
                dec.alu_src    = 1'b1;
                dec.r_size     = funct3;
                dec.dmem_size  = funct3;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.r_size    = funct3;
                dec.dmem_size = funct3;
                ImmSrcD       = IMM_S;
            end
            OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = alu_from_funct3(funct3, funct7[5], 1'b0);
            end
            OP_OP: begin
                if (funct7 == F7_MULDIV) begin
`ifdef M_EXT_EN
                    dec.reg_write  = 1'b1;
                    dec.result_src = RES_ALU;
                    dec.mul_div    = 1'b1;
                    dec.md_op      = funct3;
`else
                    known = 1'b0;
`endif
                end else begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = alu_from_funct3(funct3, funct7[5], 1'b1);
                end
            end
            default: known = 1'b0;
        endcase

        // Empty slots and unknown opcodes both become bubbles; only a real
        // instruction with an unknown opcode raises the illegal flag.
        ctrl = '0;
        if (validD) begin
            if (known) ctrl = dec;
            else       ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: decode control, ID/EX control register and the
// multi-cycle multiply/divide sequencer.
// Macro M_EXT_EN: builds RV32M decode plus the IDLE/BUSY/DONE sequencer;
// without it md_stall, md_done, MulDivE and MDOpE are constant 0.
// Parameters: MUL_CYCLES, DIV_CYCLES (1..15) execute occupancy.
// Ports:
//   clk, rst (sync, active-high)
//   validD, opcode, funct3, funct7 - decode slot
//   StallD (hold ID/EX), FlushE (bubble into ID/EX)
//   ImmSrcD - combinational immediate select
//   *E      - registered ID/EX control fields
//   md_stall - front end must hold; md_done - one-cycle result-ready pulse
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       validD,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       StallD,
    input  logic       FlushE,
    output logic [2:0] ImmSrcD,
    output logic       RegWriteE,
    output logic [1:0] ResultSrcE,
    output logic       ALUsrcE,
    output logic       MemWriteE,
    output logic       BranchE,
    output logic       JumpE,
    output logic       jalrE,
    output logic       luiE,
    output logic [2:0] R_sizeE,
    output logic [2:0] DMem_sizeE,
    output logic [3:0] ALUControlE,
    output logic       MulDivE,
    output logic [2:0] MDOpE,
    output logic       IllegalE,
    output logic       md_stall,
    output logic       md_done
);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("MUL_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be in 1..15");
    end

    ctrl_t dec_p0;
    ctrl_t idex_p1;

    ctrl_decode u_decode (
        .validD  (validD),
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .ctrl    (dec_p0),
        .ImmSrcD (ImmSrcD)
    );

    // ---- decode -> execute boundary ----
    always_ff @(posedge clk) begin
        if (rst)                       idex_p1 <= '0;
        else if (FlushE)               idex_p1 <= '0;
        else if (!(StallD || md_stall)) idex_p1 <= dec_p0;
    end

    assign RegWriteE   = idex_p1.reg_write;
    assign ResultSrcE  = idex_p1.result_src;
    assign ALUsrcE     = idex_p1.alu_src;
    assign MemWriteE   = idex_p1.mem_write;
    assign BranchE     = idex_p1.branch;
    assign JumpE       = idex_p1.jump;
    assign jalrE       = idex_p1.jalr;
    assign luiE        = idex_p1.lui;
    assign R_sizeE     = idex_p1.r_size;
    assign DMem_sizeE  = idex_p1.dmem_size;
    assign ALUControlE = idex_p1.alu_control;
    assign IllegalE    = idex_p1.illegal;

`ifdef M_EXT_EN
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    md_state_e  state, state_nx;
    logic [3:0] cnt, cnt_nx;

    assign MulDivE = idex_p1.mul_div;
    assign MDOpE   = idex_p1.md_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state)
            IDLE: begin
                // Start only when the op actually lands in ID/EX.
                if (!FlushE && !StallD && dec_p0.mul_div) begin
                    state_nx = BUSY;
                    cnt_nx   = dec_p0.md_op[2] ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                md_stall = 1'b1;
                if (FlushE) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                // A flush here squashes the result, so no completion pulse.
                md_done  = !FlushE;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
`else
    assign MulDivE  = 1'b0;
    assign MDOpE    = 3'b000;
    assign md_stall = 1'b0;
    assign md_done  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;

    localparam int MULC = 3;
    localparam int DIVC = 8;

`ifdef M_EXT_EN
    localparam bit M_ON = 1'b1;
`else
    localparam bit M_ON = 1'b0;
`endif

    localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LD = 7'b0000011,
                           T_ST = 7'b0100011, T_OPI = 7'b0010011, T_OP = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst, validD, StallD, FlushE;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [2:0] ImmSrcD;
    logic       RegWriteE, ALUsrcE, MemWriteE, BranchE, JumpE, jalrE, luiE;
    logic [1:0] ResultSrcE;
    logic [2:0] R_sizeE, DMem_sizeE, MDOpE;
    logic [3:0] ALUControlE;
    logic       MulDivE, IllegalE, md_stall, md_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst), .validD(validD), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .StallD(StallD), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .ALUsrcE(ALUsrcE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .jalrE(jalrE),
        .luiE(luiE), .R_sizeE(R_sizeE), .DMem_sizeE(DMem_sizeE),
        .ALUControlE(ALUControlE), .MulDivE(MulDivE), .MDOpE(MDOpE),
        .IllegalE(IllegalE), .md_stall(md_stall), .md_done(md_done)
    );

    logic [23:0] obs;
    assign obs = {RegWriteE, ResultSrcE, ALUsrcE, MemWriteE, BranchE, JumpE, jalrE, luiE,
                  R_sizeE, DMem_sizeE, ALUControlE, MulDivE, MDOpE, IllegalE};

    // Reference: expected ID/EX bundle for one decode-slot content.
    function automatic logic [23:0] model(input logic v, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] alu_tab [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        logic rw, as, mw, br, jp, jr, lu, md, legal;
        logic [1:0] rs;
        logic [2:0] rsz, dsz, mop;
        logic [3:0] alu;
        {rw, as, mw, br, jp, jr, lu, md} = '0;
        rs = 2'd0; rsz = 3'd2; dsz = 3'd2; mop = 3'd0; alu = 4'd0; legal = 1'b1;
        if (!v) return 24'h0;
        case (op)
            T_LUI:   begin rw = 1; as = 1; lu = 1; alu = 4'd10; end
            T_AUIPC: begin rw = 1; as = 1; end
            T_JAL:   begin rw = 1; rs = 2'd2; jp = 1; end
            T_JALR:  begin rw = 1; rs = 2'd2; jp = 1; jr = 1; as = 1; end
            T_BR:    begin br = 1; alu = 4'd1; end
            T_LD:    begin rw = 1; rs = 2'd1; as = 1; rsz = f3; dsz = f3; end
            T_ST:    begin mw = 1; as = 1; rsz = f3; dsz = f3; end
            T_OPI: begin
                rw = 1; as = 1; alu = alu_tab[f3];
                if (f3 == 3'd5 && f7[5]) alu = 4'd9;
            end
            T_OP: begin
                if (f7 == 7'd1) begin
                    if (M_ON) begin rw = 1; md = 1; mop = f3; end
                    else legal = 0;
                end else begin
                    rw = 1; alu = alu_tab[f3];
                    if (f7[5] && f3 == 3'd0) alu = 4'd1;
                    if (f7[5] && f3 == 3'd5) alu = 4'd9;
                end
            end
            default: legal = 0;
        endcase
        if (!legal) return 24'h1;
        return {rw, rs, as, mw, br, jp, jr, lu, rsz, dsz, alu, md, mop, 1'b0};
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            T_LUI, T_AUIPC: return 3'd3;
            T_JAL:          return 3'd4;
            T_BR:           return 3'd2;
            T_ST:           return 3'd1;
            default:        return 3'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] o, input logic [23:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        validD = v; opcode = op; funct3 = f3; funct7 = f7;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [10] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_OPI, T_OP, 7'h7f};
        logic [23:0] exp_q, e_md, e_add;
        logic [6:0]  r_op, r_f7;
        logic [2:0]  r_f3;
        int stall_cnt, done_cnt;
        logic seen_done;

        rst = 1; StallD = 0; FlushE = 0;
        drive(0, 7'd0, 3'd0, 7'd0);
        tick(); tick();
        check("reset_idex", obs, 24'h0);
        check("reset_md_stall", 24'(md_stall), 24'h0);
        check("reset_md_done", 24'(md_done), 24'h0);
        rst = 0;

        // ADD
        drive(1, T_OP, 3'd0, 7'd0);
        #1 check("add_imm", 24'(ImmSrcD), 24'd0);
        tick();
        check("add_regwrite", 24'(RegWriteE), 24'd1);
        check("add_alu", 24'(ALUControlE), 24'd0);
        check("add_alusrc", 24'(ALUsrcE), 24'd0);
        check("add_ressrc", 24'(ResultSrcE), 24'd0);
        check("add_illegal", 24'(IllegalE), 24'd0);

        // LB
        drive(1, T_LD, 3'd0, 7'd0);
        #1 check("lb_imm", 24'(ImmSrcD), 24'd0);
        tick();
        check("lb_ressrc", 24'(ResultSrcE), 24'd1);
        check("lb_alusrc", 24'(ALUsrcE), 24'd1);
        check("lb_rsize", 24'(R_sizeE), 24'd0);
        check("lb_bundle", obs, model(1, T_LD, 3'd0, 7'd0));

        // Unknown opcode, with and without a valid slot
        drive(1, 7'h7f, 3'd0, 7'd0);
        tick();
        check("ill_flag", 24'(IllegalE), 24'd1);
        check("ill_regwrite", 24'(RegWriteE), 24'd0);
        check("ill_memwrite", 24'(MemWriteE), 24'd0);
        drive(0, 7'h7f, 3'd0, 7'd0);
        tick();
        check("ill_novalid", 24'(IllegalE), 24'd0);

        // Stall holds, flush bubbles
        drive(1, T_OP, 3'd0, 7'h20);
        tick();
        check("sub_bundle", obs, model(1, T_OP, 3'd0, 7'h20));
        StallD = 1; drive(1, T_OP, 3'd7, 7'd0);
        tick();
        check("stall_hold", obs, model(1, T_OP, 3'd0, 7'h20));
        StallD = 0; FlushE = 1; drive(1, T_LUI, 3'd0, 7'd0);
        tick();
        check("flush_bubble", obs, 24'h0);
        FlushE = 0;

        // Randomized traffic (no multi-cycle ops)
        exp_q = 24'h0;
        for (int i = 0; i < 300; i++) begin
            r_op = ops[$urandom_range(0, 9)];
            if (r_op == 7'h7f) r_op = 7'($urandom);
            r_f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: r_f7 = 7'h00;
                1: r_f7 = 7'h20;
                2: r_f7 = 7'h01;
                default: r_f7 = 7'($urandom);
            endcase
            if (M_ON && r_f7 == 7'h01) r_f7 = 7'h00;
            drive($urandom_range(0, 3) != 0, r_op, r_f3, r_f7);
            StallD = ($urandom_range(0, 4) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 39) == 0);
            #1 check("rand_imm", 24'(ImmSrcD), 24'(exp_imm(r_op)));
            if (rst || FlushE) exp_q = 24'h0;
            else if (!StallD)  exp_q = model(validD, r_op, r_f3, r_f7);
            tick();
            check("rand_idex", obs, exp_q);
            check("rand_md_stall", 24'(md_stall), 24'h0);
        end
        rst = 0; StallD = 0; FlushE = 0;
        drive(0, 7'd0, 3'd0, 7'd0);
        tick();

`ifdef M_EXT_EN
        // DIV: DIVC stall cycles, one done cycle, ID/EX held; new decode taken in DONE
        e_md  = model(1, T_OP, 3'd4, 7'd1);
        e_add = model(1, T_OP, 3'd0, 7'd0);
        drive(1, T_OP, 3'd4, 7'd1);
        tick();
        drive(0, 7'd0, 3'd0, 7'd0);
        stall_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!md_stall && !md_done) break;
            if (md_stall) begin stall_cnt++; check("div_hold_busy", obs, e_md); end
            if (md_done) begin
                done_cnt++;
                check("div_hold_done", obs, e_md);
                drive(1, T_OP, 3'd0, 7'd0);
            end
            tick();
        end
        check("div_stall_cycles", 24'(stall_cnt), 24'(DIVC));
        check("div_done_cycles", 24'(done_cnt), 24'd1);
        check("div_then_add", obs, e_add);

        // MUL flushed in its 2nd BUSY cycle
        drive(1, T_OP, 3'd0, 7'd1);
        tick();
        drive(0, 7'd0, 3'd0, 7'd0);
        check("mul_busy1", 24'(md_stall), 24'd1);
        tick();
        check("mul_busy2", 24'(md_stall), 24'd1);
        FlushE = 1;
        tick();
        FlushE = 0;
        check("mulflush_idex", obs, 24'h0);
        check("mulflush_stall", 24'(md_stall), 24'd0);
        seen_done = md_done;
        for (int i = 0; i < 8; i++) begin tick(); seen_done |= md_done; end
        check("mulflush_no_done", 24'(seen_done), 24'd0);

        // Reset in 3rd BUSY cycle of DIV
        drive(1, T_OP, 3'd4, 7'd1);
        tick();
        drive(0, 7'd0, 3'd0, 7'd0);
        tick(); tick();
        check("divrst_busy3", 24'(md_stall), 24'd1);
        rst = 1;
        tick();
        check("divrst_idex", obs, 24'h0);
        check("divrst_stall", 24'(md_stall), 24'd0);
        check("divrst_done", 24'(md_done), 24'd0);
        rst = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); seen_done |= md_done | md_stall; end
        check("divrst_quiet", 24'(seen_done), 24'd0);

        // Flush and MUL decode together: flush wins
        FlushE = 1; drive(1, T_OP, 3'd0, 7'd1);
        tick();
        FlushE = 0; drive(0, 7'd0, 3'd0, 7'd0);
        check("flushmul_idex", obs, 24'h0);
        check("flushmul_stall", 24'(md_stall), 24'd0);
        tick();
        check("flushmul_stall2", 24'(md_stall), 24'd0);

        // StallD in IDLE blocks entry, then MUL runs MULC cycles
        StallD = 1; drive(1, T_OP, 3'd0, 7'd1);
        tick();
        check("stallmul_idle", 24'(md_stall), 24'd0);
        check("stallmul_hold", obs, 24'h0);
        StallD = 0;
        tick();
        drive(0, 7'd0, 3'd0, 7'd0);
        check("mul_bundle", obs, model(1, T_OP, 3'd0, 7'd1));
        stall_cnt = 0;
        for (int i = 0; i < 40 && md_stall; i++) begin stall_cnt++; tick(); end
        check("mul_stall_cycles", 24'(stall_cnt), 24'(MULC));
        check("mul_done_pulse", 24'(md_done), 24'd1);
        tick();

        // Flush while in DONE suppresses md_done
        drive(1, T_OP, 3'd5, 7'd1);
        tick();
        drive(0, 7'd0, 3'd0, 7'd0);
        for (int i = 0; i < 40 && md_stall; i++) tick();
        FlushE = 1;
        #1 check("doneflush_pulse", 24'(md_done), 24'd0);
        tick();
        FlushE = 0;
        check("doneflush_idex", obs, 24'h0);
        check("doneflush_stall", 24'(md_stall), 24'd0);
`else
        // Without RV32M: MUL is illegal and the sequencer stays quiet
        drive(1, T_OP, 3'd0, 7'd1);
        tick();
        check("nom_illegal", 24'(IllegalE), 24'd1);
        check("nom_bundle", obs, 24'h1);
        check("nom_stall", 24'(md_stall), 24'd0);
        drive(1, T_OP, 3'd4, 7'd1);
        tick();
        check("nom_done", 24'(md_done), 24'd0);
        check("nom_muldiv", 24'({MulDivE, MDOpE}), 24'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
